tea_interface: RTL and testbench
================================

TEA_INTERFACE -- requirements
Module: tea_interface

Interface
REQ-001 Parameter ROUNDS, default 32: number of TEA cycles (each cycle is two Feistel half-rounds).
REQ-002 Parameter DELTA, default 32'h9E3779B9: TEA key-schedule constant.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, synchronous and active-low.
REQ-005 in  input  64: key half during loading, otherwise the data block (v0=in[63:32], v1=in[31:0]).
REQ-006 mode  input  1: 0 = encrypt, 1 = decrypt.
REQ-007 writekey  input  1: starts the two-cycle key load.
REQ-008 out  output  64: result block {v0,v1}, purely combinational from in, mode and the stored key.
REQ-009 Positional port order SHALL be in, mode, writekey, clk, out, rst_n.

Function
REQ-010 State SHALL be 128-bit key register key_q (k0=key_q[127:96], k1=[95:64], k2=[63:32], k3=[31:0]) plus a 1-bit load_pending flag.
REQ-011 Rising edge with rst_n=1, load_pending=0, writekey=1: key_q[127:64] <= in, load_pending <= 1.
REQ-012 Rising edge with rst_n=1, load_pending=1: key_q[63:0] <= in, load_pending <= 0, regardless of writekey (writekey ignored that cycle, no re-arm).
REQ-013 Rising edge with rst_n=1, load_pending=0, writekey=0: key_q and load_pending hold.
REQ-014 Encrypt (mode=0): sum starts 0; each of ROUNDS cycles: sum += DELTA; v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1); v1 += ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3).
REQ-015 Decrypt (mode=1): sum starts DELTA*ROUNDS mod 2^32 (32'hC6EF3720 for defaults); each cycle: v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3); v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1); sum -= DELTA.
REQ-016 All arithmetic SHALL be unsigned 32-bit modulo 2^32; shifts logical; >>5 zero-fills.
REQ-017 Datapath SHALL be fully unrolled combinational logic (no pipeline registers); out settles within the same cycle as any change of in, mode or key_q, zero clock latency.
REQ-018 out SHALL use key_q as currently registered; during the cycle between halves it uses the new high half and old low half (no gating, out always valid per current key_q).
REQ-019 Decrypt(encrypt(x)) SHALL equal x for any key and x.
REQ-020 No handshake or valid/busy outputs; the block accepts new data every cycle.

Reset
REQ-021 Rising edge with rst_n=0: key_q <= 0, load_pending <= 0; reset has priority over writekey and load_pending.
REQ-022 After reset, out = TEA(key=0) of in per mode; a reset between the two key halves aborts the load (next edge does not capture a low half).

Verification
REQ-023 Reset, in=0, mode=0 -> out = 64'h41EA3A0A94BAA940; mode=1 with in=64'h41EA3A0A94BAA940 -> out=0.
REQ-024 writekey=1 with in=64'h1234567890ABCDEF, next edge writekey=0 with in=64'hFEDCBA0987654321 -> key_q=128'h1234567890ABCDEFFEDCBA0987654321, load_pending=0.
REQ-025 With that key, in=64'h1234567890ABCDEF mode=0 -> out=C; then in=C mode=1, no clock edge -> out=64'h1234567890ABCDEF combinationally.
REQ-026 writekey held 1 for three edges with in=A,B,C -> hi=A, lo=B, then third edge starts a new load with hi=C, pending=1.
REQ-027 rst_n=0 on the edge following the high-half load -> key_q=0, pending=0; following edge with writekey=0 leaves key_q=0.
REQ-028 Random sweep of 1000 keys/blocks -> out matches a software TEA model for both modes and decrypt(encrypt(x))=x.

Source files
------------

// File: rtl/tea_interface.sv
// tea_interface: fully unrolled combinational TEA encrypt/decrypt with a two-cycle 128-bit key load.
module tea_interface #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic [63:0] in,
  input  logic        mode,
  input  logic        writekey,
  input  logic        clk,
  output logic [63:0] out,
  input  logic        rst_n
);
  localparam logic [31:0] SUM0 = DELTA * ROUNDS;
  logic [127:0] key_q;
  logic         load_pending;
  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  e0, e1, es, d0, d1, ds;
  assign {k0, k1, k2, k3} = key_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q        <= '0;
      load_pending <= 1'b0;
    end else if (load_pending) begin
      key_q[63:0]  <= in;
      load_pending <= 1'b0;
    end else if (writekey) begin
      key_q[127:64] <= in;
      load_pending  <= 1'b1;
    end
  end
  // Both directions are evaluated every cycle; mode only picks the result.
  always_comb begin
    e0 = in[63:32];
    e1 = in[31:0];
    es = '0;
    d0 = in[63:32];
    d1 = in[31:0];
    ds = SUM0;
    for (int i = 0; i < ROUNDS; i++) begin
      es = es + DELTA;
      e0 = e0 + (((e1 << 4) + k0) ^ (e1 + es) ^ ((e1 >> 5) + k1));
      e1 = e1 + (((e0 << 4) + k2) ^ (e0 + es) ^ ((e0 >> 5) + k3));
      d1 = d1 - (((d0 << 4) + k2) ^ (d0 + ds) ^ ((d0 >> 5) + k3));
      d0 = d0 - (((d1 << 4) + k0) ^ (d1 + ds) ^ ((d1 >> 5) + k1));
      ds = ds - DELTA;
    end
    out = mode ? {d0, d1} : {e0, e1};
  end
endmodule

// File: tb/tb_tea_interface.sv
// tb_tea_interface: directed and random checks of tea_interface against a reference TEA model.
module tb_tea_interface;
  localparam int          ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;
  logic [63:0] in;
  logic        mode, writekey, clk, rst_n;
  logic [63:0] out;
  int          passed, total;
  logic [127:0] mk;
  logic         mp, chk_en;
  tea_interface #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
    .in(in), .mode(mode), .writekey(writekey), .clk(clk), .out(out), .rst_n(rst_n)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [63:0] tea(input logic [127:0] k, input logic [63:0] v, input logic m);
    logic [31:0] a, b, s;
    a = v[63:32];
    b = v[31:0];
    if (!m) begin
      s = 0;
      repeat (ROUNDS) begin
        s += DELTA;
        a += ((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]);
        b += ((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]);
      end
    end else begin
      s = DELTA * ROUNDS;
      repeat (ROUNDS) begin
        b -= ((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]);
        a -= ((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]);
        s -= DELTA;
      end
    end
    return {a, b};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // Key-register model: a two-phase loader driven by the same sampled inputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      mk = '0;
      mp = 1'b0;
    end else if (mp) begin
      mk = {mk[127:64], in};
      mp = 1'b0;
    end else if (writekey) begin
      mk = {in, mk[63:0]};
      mp = 1'b1;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("out", {64'b0, out}, {64'b0, tea(mk, in, mode)});
    chk("key_q", dut.key_q, mk);
    chk("pending", {127'b0, dut.load_pending}, {127'b0, mp});
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic load_key(input logic [127:0] k);
    writekey = 1'b1; in = k[127:64];
    step();
    writekey = 1'b0; in = k[63:0];
    step();
  endtask
  initial begin
    logic [63:0] x, c;
    logic [127:0] k;
    passed = 0; total = 0; chk_en = 1'b0;
    mk = '0; mp = 1'b0;
    rst_n = 1'b0; writekey = 1'b0; mode = 1'b0; in = '0;
    step();
    chk_en = 1'b1;
    rst_n = 1'b1;
    #1 chk("zero_key_enc", {64'b0, out}, {64'b0, 64'h41EA3A0A94BAA940});
    mode = 1'b1; in = 64'h41EA3A0A94BAA940;
    #1 chk("zero_key_dec", {64'b0, out}, 128'b0);
    chk("model_pin", {64'b0, tea(128'b0, 64'b0, 1'b0)}, {64'b0, 64'h41EA3A0A94BAA940});
    mode = 1'b0;
    load_key({64'h1234567890ABCDEF, 64'hFEDCBA0987654321});
    chk("key_load", dut.key_q, 128'h1234567890ABCDEFFEDCBA0987654321);
    chk("key_pending", {127'b0, dut.load_pending}, 128'b0);
    in = 64'h1234567890ABCDEF; mode = 1'b0;
    #1 c = out;
    in = c; mode = 1'b1;
    #1 chk("comb_roundtrip", {64'b0, out}, {64'b0, 64'h1234567890ABCDEF});
    step();
    writekey = 1'b1; in = 64'hAAAA0000AAAA0001;
    step();
    in = 64'hBBBB0000BBBB0002;
    step();
    in = 64'hCCCC0000CCCC0003;
    step();
    chk("held_hi", {64'b0, dut.key_q[127:64]}, {64'b0, 64'hCCCC0000CCCC0003});
    chk("held_lo", {64'b0, dut.key_q[63:0]}, {64'b0, 64'hBBBB0000BBBB0002});
    chk("held_pend", {127'b0, dut.load_pending}, 128'b1);
    writekey = 1'b0; in = 64'h0;
    step();
    writekey = 1'b1; in = 64'h5555AAAA5555AAAA;
    step();
    writekey = 1'b0; rst_n = 1'b0; in = 64'h0123456789ABCDEF;
    step();
    chk("abort_key", dut.key_q, 128'b0);
    chk("abort_pend", {127'b0, dut.load_pending}, 128'b0);
    rst_n = 1'b1; in = 64'h0F0F0F0F0F0F0F0F;
    step();
    chk("abort_hold", dut.key_q, 128'b0);
    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k);
      x = {$urandom, $urandom};
      in = x; mode = 1'b0;
      #1 c = out;
      in = c; mode = 1'b1;
      #1 chk("rand_roundtrip", {64'b0, out}, {64'b0, x});
      step();
    end
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
